passive_arming_fsm: RTL and testbench
=====================================

# passive_arming_fsm

- Passive-arming controller for the car alarm; it consumes the three vehicle status signals produced by the tester: `CarLightsOnSign`, `OpenDoorSign` and `IgnitionSignalOn`.
- After the driver switches off the ignition, opens the door and closes it again, the block counts a fixed closed-door delay and then raises `PassiveSignal`.
- It also produces a lights-left-on chime and state/status outputs for the data monitor.
- It is sequential (FSM plus counter) and replaces the combinational passive-signal logic in the next revision of the design.

## Interface
Parameters:
- `ARM_DELAY`, default 6: number of `clk` cycles the door must stay closed in COUNTDOWN before arming. Legal range is 1 to 2^`CNT_W`−1.
- `CNT_W`, default 4: width of the countdown counter.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge triggered.
- `reset_L`  in  1: asynchronous, active-low reset.
- `IgnitionSignalOn`  in  1: ignition is on.
- `OpenDoorSign`  in  1: driver door is open.
- `CarLightsOnSign`  in  1: headlights are on.
- `PassiveSignal`  out  1: vehicle is passively armed.
- `ArmPending`  out  1: countdown is in progress.
- `LightsChime`  out  1: warning that the lights are on with the ignition off and the door open.
- `ArmState`  out  3: current FSM state encoding, for the monitor.

## Operation
- All inputs are synchronous to `clk`; the block contains no synchronizers.
- All outputs are flop outputs or decoded directly from the state register. There is no combinational input-to-output path.

States and `ArmState` encoding:
- IDLE = 0
- WAIT_OPEN = 1
- WAIT_CLOSE = 2
- COUNTDOWN = 3
- ARMED = 4
- Codes 5 to 7 are illegal and go to IDLE on the next edge.

Transitions, evaluated at each rising edge:
- Highest priority, from any state: `IgnitionSignalOn`=1 → IDLE, counter cleared.
- IDLE: ignition off → WAIT_OPEN.
- WAIT_OPEN: `OpenDoorSign`=1 → WAIT_CLOSE.
- WAIT_CLOSE: `OpenDoorSign`=0 → COUNTDOWN, counter loaded with 0.
- COUNTDOWN, door open: → WAIT_CLOSE, counter cleared. The full delay restarts on the next close.
- COUNTDOWN, door closed: if counter == `ARM_DELAY`−1 → ARMED; otherwise counter +1.
- ARMED: stays ARMED whatever the door and lights do. Only ignition disarms. Intrusion detection is a downstream block.

Outputs:
- `PassiveSignal` = 1 only in state ARMED.
- `ArmPending` = 1 only in state COUNTDOWN.
- `LightsChime` is registered every edge as `!IgnitionSignalOn & CarLightsOnSign & OpenDoorSign`. It is independent of the FSM.

Counter:
- `CNT_W` bits, unsigned.
- Never exceeds `ARM_DELAY`−1, so it cannot wrap.

## Timing
Reset:
- When `reset_L`=0, asynchronously and without waiting for a clock: state IDLE, counter 0, `PassiveSignal`=0, `ArmPending`=0, `LightsChime`=0, `ArmState`=0.
- Reset asserted mid-countdown or while ARMED drops every output immediately.
- After `reset_L` rises, the first rising edge evaluates normally from IDLE.

Arming latency:
- Edge E0 samples the door closed in WAIT_CLOSE and enters COUNTDOWN.
- `PassiveSignal` rises after edge E0+`ARM_DELAY`, so `ArmPending` is high for exactly `ARM_DELAY` cycles.
- From ignition falling, the minimum time to arm is 3+`ARM_DELAY` edges. This requires the door to open on the edge after WAIT_OPEN is entered and close on the following edge.

Disarm latency:
- `IgnitionSignalOn`=1 sampled at edge E → `PassiveSignal`=0 and `ArmState`=0 after E.

`LightsChime` latency:
- One cycle after the input condition appears and one cycle after it clears.

Simultaneous events:
- Ignition on together with the door closing in WAIT_CLOSE → IDLE; ignition wins.
- Door reopening on the same edge the counter reaches `ARM_DELAY`−1 → WAIT_CLOSE, not ARMED.
- Ignition off and door open on the same edge in IDLE → WAIT_OPEN only. The door must then still be open, or reopen, on the next edge.

## Test plan
1. Reset and basic arm: assert `reset_L`=0 mid-run, so all outputs = 0 at once. Then ignition 1→0, door 0→1→0 on consecutive edges. Require `ArmState` sequence 1, 2, 3. `ArmPending` high for 6 cycles, then `PassiveSignal`=1 and `ArmState`=4.
2. Countdown restart: with `ArmPending` high, reopen the door after 4 counted cycles. Require `ArmState`=2 and `ArmPending`=0. On the re-close, a full 6 cycles are needed before `PassiveSignal`=1.
3. Disarm: while ARMED, toggle the door and confirm `PassiveSignal` stays 1. Set ignition=1, so `PassiveSignal`=0 and `ArmState`=0 after one edge.
4. Ignition priority: in WAIT_CLOSE, apply ignition=1 and door=0 on the same edge → `ArmState`=0, never 3.
5. Chime: ignition 0, lights 1, door 1 → `LightsChime`=1 one edge later. Set lights 0 → `LightsChime`=0 one edge later. Ignition 1 with lights and door at 1 → `LightsChime`=0.
6. Boundary parameter: with `ARM_DELAY`=1 and `CNT_W`=1, `ArmPending` is high for exactly 1 cycle, then `PassiveSignal`=1.

Source files
------------

// File: rtl/passive_arming_fsm.sv
// passive_arming_fsm: arms the alarm after ignition off, door open/close and a closed-door delay.
// Also registers a lights-left-on chime and exposes the state for the monitor.
module passive_arming_fsm #(
    parameter int ARM_DELAY = 6,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       IgnitionSignalOn,
    input  logic       OpenDoorSign,
    input  logic       CarLightsOnSign,
    output logic       PassiveSignal,
    output logic       ArmPending,
    output logic       LightsChime,
    output logic [2:0] ArmState
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_OPEN  = 3'd1,
        WAIT_CLOSE = 3'd2,
        COUNTDOWN  = 3'd3,
        ARMED      = 3'd4
    } armState_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ARM_DELAY - 1);

    armState_t        state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state       <= IDLE;
            count       <= '0;
            LightsChime <= 1'b0;
        end else begin
            LightsChime <= !IgnitionSignalOn & CarLightsOnSign & OpenDoorSign;
            if (IgnitionSignalOn) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE:       state <= WAIT_OPEN;
                    WAIT_OPEN:  if (OpenDoorSign) state <= WAIT_CLOSE;
                    WAIT_CLOSE: if (!OpenDoorSign) begin
                        state <= COUNTDOWN;
                        count <= '0;
                    end
                    // Reopening restarts the full delay on the next close.
                    COUNTDOWN:  if (OpenDoorSign) begin
                        state <= WAIT_CLOSE;
                        count <= '0;
                    end else if (count == LAST_COUNT) begin
                        state <= ARMED;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                    ARMED:      state <= ARMED;
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    assign ArmState      = state;
    assign PassiveSignal = (state == ARMED);
    assign ArmPending    = (state == COUNTDOWN);
endmodule

// File: tb/tb_passive_arming_fsm.sv
// tb_passive_arming_fsm: checks two configurations (delay 6 and delay 1) against an event-history model.
module tb_passive_arming_fsm;
    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic ign = 1'b1, door = 1'b0, lights = 1'b0;
    logic       ps [2];
    logic       ap [2];
    logic       lc [2];
    logic [2:0] st [2];
    int checks = 0, failures = 0;
    bit live = 1'b0;

    always #5 clk = ~clk;

    passive_arming_fsm dut6 (
        .clk(clk), .reset_L(reset_L), .IgnitionSignalOn(ign), .OpenDoorSign(door),
        .CarLightsOnSign(lights), .PassiveSignal(ps[0]), .ArmPending(ap[0]),
        .LightsChime(lc[0]), .ArmState(st[0])
    );
    passive_arming_fsm #(.ARM_DELAY(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset_L(reset_L), .IgnitionSignalOn(ign), .OpenDoorSign(door),
        .CarLightsOnSign(lights), .PassiveSignal(ps[1]), .ArmPending(ap[1]),
        .LightsChime(lc[1]), .ArmState(st[1])
    );

    // Model: progress tracked as ignition-off seen, door-opened seen, closed-edge run length.
    int delay [2] = '{6, 1};
    int offSeen [2], opened [2], closedRun [2], armed [2];
    bit chime;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int j = 0; j < 2; j++) begin
                offSeen[j] <= 0; opened[j] <= 0; closedRun[j] <= 0; armed[j] <= 0;
            end
            chime <= 1'b0;
        end else begin
            chime <= !ign && lights && door;
            for (int j = 0; j < 2; j++) begin
                if (ign) begin
                    offSeen[j] <= 0; opened[j] <= 0; closedRun[j] <= 0; armed[j] <= 0;
                end else if (armed[j] != 0) begin
                    armed[j] <= 1;
                end else if (offSeen[j] == 0) begin
                    offSeen[j] <= 1;
                end else if (opened[j] == 0) begin
                    opened[j] <= int'(door);
                end else if (door) begin
                    closedRun[j] <= 0;
                end else begin
                    closedRun[j] <= closedRun[j] + 1;
                    if (closedRun[j] + 1 == delay[j] + 1) armed[j] <= 1;
                end
            end
        end
    end

    function automatic int expState(int j);
        if (armed[j] != 0) return 4;
        if (offSeen[j] == 0) return 0;
        if (opened[j] == 0) return 1;
        return (closedRun[j] == 0) ? 2 : 3;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            for (int j = 0; j < 2; j++) begin
                chk(j == 0 ? "model_state_d6" : "model_state_d1", int'(st[j]), expState(j));
                chk(j == 0 ? "model_passive_d6" : "model_passive_d1", int'(ps[j]), int'(expState(j) == 4));
                chk(j == 0 ? "model_pending_d6" : "model_pending_d1", int'(ap[j]), int'(expState(j) == 3));
                chk(j == 0 ? "model_chime_d6" : "model_chime_d1", int'(lc[j]), int'(chime));
            end
        end
    end

    task automatic cyc(input logic i, input logic d, input logic l);
        ign = i; door = d; lights = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 reset_L = 1'b1;
        live = 1'b1;
        @(posedge clk); #1;
        cyc(1, 0, 0);
        // Walk into COUNTDOWN, then reset mid-cycle
        cyc(0, 0, 0); cyc(0, 1, 1); cyc(0, 0, 0);
        chk("pre_reset_pending", int'(ap[0]), 1);
        #2 reset_L = 1'b0;
        #1;
        chk("reset_state", int'(st[0]), 0);
        chk("reset_outputs", int'({ps[0], ap[0], lc[0], ps[1], ap[1], lc[1]}), 0);
        ign = 1'b1;
        #1 reset_L = 1'b1;
        @(posedge clk); #1;
        // Test 1: basic arm
        cyc(1, 0, 0);
        cyc(0, 0, 0); chk("seq_wait_open", int'(st[0]), 1);
        cyc(0, 1, 0); chk("seq_wait_close", int'(st[0]), 2);
        cyc(0, 0, 0); chk("seq_countdown", int'(st[0]), 3);
        chk("d1_pending", int'(ap[1]), 1);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0);
            chk("d6_pending_hold", int'(ap[0]), 1);
            if (k == 1) chk("d1_armed_after_one", int'(st[1]), 4);
        end
        cyc(0, 0, 0);
        chk("d6_armed_passive", int'(ps[0]), 1);
        chk("d6_armed_state", int'(st[0]), 4);
        // Test 3: disarm
        cyc(0, 1, 1); cyc(0, 0, 0);
        chk("armed_door_toggle", int'(ps[0]), 1);
        cyc(1, 0, 0);
        chk("disarm_passive", int'(ps[0]), 0);
        chk("disarm_state", int'(st[0]), 0);
        // Test 2: countdown restart after four counted cycles
        cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("restart_state", int'(st[0]), 2);
        chk("restart_pending", int'(ap[0]), 0);
        cyc(0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        chk("restart_not_yet", int'(ps[0]), 0);
        cyc(0, 0, 0);
        chk("restart_armed", int'(ps[0]), 1);
        // Test 4: ignition wins over door close
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
        cyc(1, 0, 0);
        chk("ign_priority", int'(st[0]), 0);
        // Ignition off with door open in IDLE only reaches WAIT_OPEN
        cyc(0, 1, 0); chk("idle_door_same_edge", int'(st[0]), 1);
        cyc(0, 0, 0); chk("needs_reopen", int'(st[0]), 1);
        // Door reopening at the final count goes back to WAIT_CLOSE
        cyc(0, 1, 0); cyc(0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("reopen_at_last", int'(st[0]), 2);
        // Test 5: chime
        cyc(1, 0, 0);
        cyc(0, 1, 1); chk("chime_on", int'(lc[0]), 1);
        cyc(0, 1, 0); chk("chime_off_lights", int'(lc[0]), 0);
        cyc(0, 1, 1); chk("chime_on_again", int'(lc[0]), 1);
        cyc(1, 1, 1); chk("chime_ign", int'(lc[0]), 0);
        cyc(1, 0, 0);
        @(negedge clk);
        live = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
